// File: rtl/sop_logic_pipe.sv
// rtl/sop_logic_pipe.sv - two-stage pipelined sum-of-products unit with runtime input mask
module sop_logic_pipe #(
    parameter int CH    = 2,
    parameter int TERMS = 2,
    parameter int TIN   = 3,
    parameter int CW    = 16
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH*TERMS*TIN-1:0]   in_data,
    input  logic [1:0]                in_mode,
    input  logic                      cfg_we,
    input  logic [CH*TERMS*TIN-1:0]   cfg_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH-1:0]             out_y,
    output logic [CH-1:0]             out_y_n,
    output logic [CW-1:0]             xfer_count
);

    localparam int NT = CH * TERMS;
    localparam int NB = NT * TIN;

    localparam logic [1:0] M_SOP  = 2'b00;
    localparam logic [1:0] M_POS  = 2'b01;
    localparam logic [1:0] M_XSOP = 2'b10;
    localparam logic [1:0] M_NSOP = 2'b11;

    logic [NB-1:0]  mask;
    logic           s1_v;
    logic [NT-1:0]  s1_terms;
    logic [1:0]     s1_mode;
    logic [NT-1:0]  and_t;
    logic [NT-1:0]  or_t;
    logic [NT-1:0]  terms;
    logic [CH-1:0]  y_next;
    logic           s1_en;
    logic           s2_en;
    logic           accept;

    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_v | s2_en;
    assign in_ready = s1_en;
    assign accept   = in_valid & s1_en;
    assign out_y_n  = ~out_y;

    // Masked inputs simply drop out of the reduction, so an empty term is the identity.
    always_comb begin
        and_t = '1;
        or_t  = '0;
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < TIN; i++) begin
                if (mask[t*TIN+i]) begin
                    and_t[t] = and_t[t] & in_data[t*TIN+i];
                    or_t[t]  = or_t[t] | in_data[t*TIN+i];
                end
            end
        end
        terms = (in_mode == M_POS) ? or_t : and_t;
    end

    always_comb begin
        y_next = '0;
        for (int c = 0; c < CH; c++) begin
            case (s1_mode)
                M_SOP:   y_next[c] = |s1_terms[c*TERMS +: TERMS];
                M_POS:   y_next[c] = &s1_terms[c*TERMS +: TERMS];
                M_XSOP:  y_next[c] = ^s1_terms[c*TERMS +: TERMS];
                M_NSOP:  y_next[c] = ~|s1_terms[c*TERMS +: TERMS];
                default: y_next[c] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            mask       <= '1;
            s1_v       <= 1'b0;
            s1_terms   <= '0;
            s1_mode    <= M_SOP;
            out_valid  <= 1'b0;
            out_y      <= '0;
            xfer_count <= '0;
        end else begin
            if (cfg_we) begin
                mask <= cfg_mask;
            end
            if (s1_en) begin
                s1_v <= in_valid;
                if (accept) begin
                    s1_terms <= terms;
                    s1_mode  <= in_mode;
                end
            end
            if (s2_en) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_y <= y_next;
                end
            end
            if (out_valid && out_ready && (xfer_count != {CW{1'b1}})) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

endmodule
